freq_key_entry: RTL

- Button-driven producer of the 9-bit frequency control word `keyin` that the 7-segment frequency display consumes.
- The display shows `keyin/16`, so this block keeps `keyin` on a 16-code grid.
- Two raw, bouncing, active-low push-buttons step the word up or down, with debounce, press-and-hold auto-repeat and saturation.
- Sits between the board keys and both the DDS phase-increment path and the display.

---
 rtl/freq_key_entry.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/freq_key_entry.sv
// freq_key_entry
//   Button-driven producer of the 9-bit frequency control word shown on the
//   7-segment display (display value = keyin/16). Two raw active-low keys
//   are synchronised, debounced, and stepped through an IDLE/HOLD/REPEAT/LOCK
//   FSM that gives a single step on press, then auto-repeat while held.
//   The word saturates at 0 and MAX_CODE and never wraps.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   key_up_n    in   raw up button, active-low, asynchronous to clk
//   key_down_n  in   raw down button, active-low, asynchronous to clk
//   keyin       out  [8:0] frequency control word, registered
//   changed     out  one-cycle pulse in the cycle keyin takes a new value

// Per-key synchroniser + debouncer.
//   clk, rst_n  clock / async active-low reset
//   key_n_i     raw active-low key
//   pressed_o   debounced pressed state (1 = pressed)
module freq_key_debounce #(
  parameter int unsigned CYCLES = 4,
  parameter int unsigned W      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic pressed_o
);

  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic         sync1_q, sync2_q;
  logic         db_q, db_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         press;

  assign press = ~sync2_q;

  // Any sample that agrees with the accepted level restarts the count,
  // so a bounce shorter than CYCLES samples is never accepted.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (press != db_q) begin
      if (cnt_q == LAST) begin
        db_d  = press;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed_o = db_q;

endmodule

module freq_key_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 10000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int unsigned STEP            = 16,
  parameter int unsigned MAX_CODE        = 496,
  parameter int unsigned INIT_CODE       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  output logic [8:0] keyin,
  output logic       changed
);

  localparam int unsigned NUM_KEYS = 2;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [9:0]    STEP10      = 10'(STEP);
  localparam logic [9:0]    MAX10       = 10'(MAX_CODE);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_e;

  // Key index 0 = up, 1 = down.
  logic [NUM_KEYS-1:0] key_n, pressed;
  assign key_n = {key_down_n, key_up_n};

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      freq_key_debounce #(.CYCLES(DEBOUNCE_CYCLES), .W(DB_W)) u_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n_i   (key_n[g]),
        .pressed_o (pressed[g])
      );
    end
  endgenerate

  logic up, dn;
  assign up = pressed[0];
  assign dn = pressed[1];

  state_e        state_q, state_d;
  logic          dir_q, dir_d;     // 1 = stepping up
  logic [TW-1:0] timer_q, timer_d;
  logic [8:0]    keyin_q, keyin_d;
  logic          changed_q, changed_d;

  logic       step, step_up, held, other;
  logic [9:0] cur, sum, up_val, dn_val, nxt;

  // Held/other are relative to the direction latched when the hold began.
  assign held  = dir_q ? up : dn;
  assign other = dir_q ? dn : up;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    step    = 1'b0;
    step_up = dir_q;
    unique case (state_q)
      IDLE: begin
        if (up && dn) begin
          state_d = LOCK;
        end else if (up || dn) begin
          step    = 1'b1;
          step_up = up;
          dir_d   = up;
          timer_d = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!held)                      state_d = IDLE;
        else if (other)                 state_d = LOCK;
        else if (timer_q == DELAY_LAST) begin
          step    = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else                        timer_d = timer_q + TW'(1);
      end
      REPEAT: begin
        if (!held)                       state_d = IDLE;
        else if (other)                  state_d = LOCK;
        else if (timer_q == PERIOD_LAST) begin
          step    = 1'b1;
          timer_d = '0;
        end else                         timer_d = timer_q + TW'(1);
      end
      LOCK: begin
        if (!up && !dn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating step in 10 bits so the up sum cannot wrap before clamping.
  assign cur    = {1'b0, keyin_q};
  assign sum    = cur + STEP10;
  assign up_val = (sum > MAX10) ? MAX10 : sum;
  assign dn_val = (cur < STEP10) ? 10'd0 : (cur - STEP10);
  assign nxt    = step_up ? up_val : dn_val;

  always_comb begin
    keyin_d   = keyin_q;
    changed_d = 1'b0;
    if (step) begin
      keyin_d   = nxt[8:0];
      changed_d = (nxt[8:0] != keyin_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 1'b1;
      timer_q   <= '0;
      keyin_q   <= 9'(INIT_CODE);
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      keyin_q   <= keyin_d;
      changed_q <= changed_d;
    end
  end

  assign keyin   = keyin_q;
  assign changed = changed_q;

endmodule
